ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one word-wide RAM port between a file-download writer and a CPU.
//   Download words land in a small FIFO and are written to RAM ahead of any
//   CPU access. The CPU is held in reset while a download is active, while
//   buffered words remain, and for RESET_HOLD cycles after both go idle.
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   dl_downloading               level, download in progress
//   dl_wr, dl_addr, dl_data      one-cycle download word strobe + payload
//   cpu_req, cpu_we, cpu_addr,
//   cpu_wdata                    CPU access request (held until cpu_ack)
//   cpu_ack, cpu_rdata           one-cycle completion pulse + read data
//   cpu_reset                    holds the CPU in reset
//   ram_req, ram_we, ram_addr,
//   ram_wdata                    RAM request (registered, stable until ack)
//   ram_ack, ram_rdata           RAM completion pulse + same-cycle read data
//   dl_overflow                  sticky, a download word was dropped
//   dbg_state                    current arbiter state (IDLE=0, DL=1, CPU=2)
//
// Handshake: ram_req is a level that, once raised, holds ram_we/ram_addr/
// ram_wdata unchanged until ram_ack is sampled high; the access completes on
// that edge and ram_req drops on it. ram_ack while no access is pending is
// ignored. cpu_req likewise is held by the CPU until the cpu_ack pulse.
module ram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_downloading,
  input  logic        dl_wr,
  input  logic [24:0] dl_addr,
  input  logic [15:0] dl_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic        cpu_reset,
  output logic        ram_req,
  output logic        ram_we,
  output logic [24:0] ram_addr,
  output logic [15:0] ram_wdata,
  input  logic        ram_ack,
  input  logic [15:0] ram_rdata,
  output logic        dl_overflow,
  output logic [1:0]  dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(RESET_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DL_ACC  = 2'd1,
    CPU_ACC = 2'd2
  } state_t;

  state_t state;

  // Download FIFO storage: {addr, data}
  logic [40:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_nonempty;
  logic          push;
  logic          pop;
  logic [40:0]   head;

  logic [HW-1:0] hold_cnt;
  logic          dl_downloading_q;

  assign fifo_full     = (count == CW'(FIFO_DEPTH));
  assign fifo_nonempty = (count != '0);
  assign pop           = (state == DL_ACC) && ram_ack;
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign push          = dl_wr && (!fifo_full || pop);
  assign head          = fifo_mem[rd_ptr];

  assign cpu_reset = dl_downloading | fifo_nonempty | (hold_cnt != '0);
  assign dbg_state = state;

  // FIFO storage has no reset; occupancy is governed by count alone.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_ptr] <= {dl_addr, dl_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      dl_overflow      <= 1'b0;
      dl_downloading_q <= 1'b0;
      hold_cnt         <= HW'(RESET_HOLD);
    end else begin
      dl_downloading_q <= dl_downloading;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      // A word dropped on the same cycle as a new download start still counts.
      if (dl_wr && !push)                          dl_overflow <= 1'b1;
      else if (dl_downloading && !dl_downloading_q) dl_overflow <= 1'b0;

      if (dl_downloading || fifo_nonempty) hold_cnt <= HW'(RESET_HOLD);
      else if (hold_cnt != '0)             hold_cnt <= hold_cnt - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (fifo_nonempty) begin
            state     <= DL_ACC;
            ram_req   <= 1'b1;
            ram_we    <= 1'b1;
            ram_addr  <= head[40:16];
            ram_wdata <= head[15:0];
          end else if (cpu_req && !cpu_reset) begin
            state     <= CPU_ACC;
            ram_req   <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
          end
        end
        DL_ACC: begin
          if (ram_ack) begin
            state   <= IDLE;
            ram_req <= 1'b0;
          end
        end
        CPU_ACC: begin
          // Completes even if cpu_reset rose during the access.
          if (ram_ack) begin
            state     <= IDLE;
            ram_req   <= 1'b0;
            cpu_ack   <= 1'b1;
            cpu_rdata <= ram_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          ram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with default parameters
// (FIFO_DEPTH=4, RESET_HOLD=16). Inputs change and outputs are sampled on
// the falling edge; the DUT acts on the rising edge.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dl_downloading = 1'b0;
  logic        dl_wr = 1'b0;
  logic [24:0] dl_addr = '0;
  logic [15:0] dl_data = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [24:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        cpu_reset;
  logic        ram_req;
  logic        ram_we;
  logic [24:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_ack = 1'b0;
  logic [15:0] ram_rdata = '0;
  logic        dl_overflow;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected download writes, {addr, data}, in order
  logic [40:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [24:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          dly;
    logic [15:0] exp_rdata;
  } cpu_vec_t;

  cpu_vec_t vecs[5];

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .dl_downloading(dl_downloading), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_reset(cpu_reset),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .dl_overflow(dl_overflow), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_req(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= max; i++) begin
      if (ram_req) begin
        ok = 1'b1;
        break;
      end
      if (i < max) tick();
    end
    check("ram_req_timeout", 32'(ok), 32'd1);
  endtask

  // Services one RAM write from the download path and checks it against
  // the head of the expected queue.
  task automatic dl_service();
    bit ok;
    logic [40:0] e;
    e = exp_q.pop_front();
    wait_req(30, ok);
    if (ok) begin
      check("dl_we",    32'(ram_we),    32'd1);
      check("dl_addr",  32'(ram_addr),  32'(e[40:16]));
      check("dl_wdata", 32'(ram_wdata), 32'(e[15:0]));
      tick();
      check("dl_stable_req",  32'(ram_req),  32'd1);
      check("dl_stable_addr", 32'(ram_addr), 32'(e[40:16]));
      ram_ack = 1'b1;
      tick();
      ram_ack = 1'b0;
      check("dl_req_drop", 32'(ram_req), 32'd0);
    end
  endtask

  task automatic cpu_access(input cpu_vec_t v);
    bit ok;
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    wait_req(30, ok);
    if (ok) begin
      for (int d = 0; d <= v.dly; d++) begin
        check("cpu_ram_req",   32'(ram_req),   32'd1);
        check("cpu_ram_we",    32'(ram_we),    32'(v.we));
        check("cpu_ram_addr",  32'(ram_addr),  32'(v.addr));
        check("cpu_ram_wdata", 32'(ram_wdata), 32'(v.wdata));
        if (d < v.dly) tick();
      end
      ram_ack = 1'b1; ram_rdata = v.rdata;
      tick();
      ram_ack = 1'b0; ram_rdata = 16'(~v.rdata);
      check("cpu_ack",      32'(cpu_ack),   32'd1);
      check("cpu_rdata",    32'(cpu_rdata), 32'(v.exp_rdata));
      check("cpu_req_drop", 32'(ram_req),   32'd0);
      cpu_req = 1'b0;
      tick();
      check("cpu_ack_pulse", 32'(cpu_ack),   32'd0);
      check("cpu_rdata_hold", 32'(cpu_rdata), 32'(v.exp_rdata));
    end else begin
      cpu_req = 1'b0;
    end
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    bit ok;

    vecs[0] = '{we: 1'b0, addr: 25'h0000100, wdata: 16'h0000, rdata: 16'hA5A5, dly: 0, exp_rdata: 16'hA5A5};
    vecs[1] = '{we: 1'b1, addr: 25'h1FFFFFF, wdata: 16'hFFFF, rdata: 16'h1111, dly: 2, exp_rdata: 16'h1111};
    vecs[2] = '{we: 1'b0, addr: 25'h0000000, wdata: 16'h1234, rdata: 16'h0000, dly: 1, exp_rdata: 16'h0000};
    vecs[3] = '{we: 1'b1, addr: 25'h0AAAAAA, wdata: 16'h5A5A, rdata: 16'hC3C3, dly: 3, exp_rdata: 16'hC3C3};
    vecs[4] = '{we: 1'b0, addr: 25'h1555555, wdata: 16'h0001, rdata: 16'hFFFF, dly: 0, exp_rdata: 16'hFFFF};

    // Reset state
    tick(); tick();
    check("rst_ram_req",   32'(ram_req),     32'd0);
    check("rst_ram_we",    32'(ram_we),      32'd0);
    check("rst_ram_addr",  32'(ram_addr),    32'd0);
    check("rst_ram_wdata", 32'(ram_wdata),   32'd0);
    check("rst_cpu_ack",   32'(cpu_ack),     32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata),   32'd0);
    check("rst_overflow",  32'(dl_overflow), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset),   32'd1);
    reset = 1'b0;

    // cpu_reset high for exactly 16 cycles after reset release
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("hold_after_reset", 32'(cpu_reset), 32'(k < 16));
    end

    // Table-driven CPU accesses
    for (int i = 0; i < 5; i++) cpu_access(vecs[i]);

    // Single download write, ack after 3 cycles
    dl_downloading = 1'b1;
    dl_wr = 1'b1; dl_addr = 25'h0800000; dl_data = 16'h1234;
    tick();
    dl_wr = 1'b0;
    check("dl_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("dl1_req",   32'(ram_req),   32'd1);
    check("dl1_we",    32'(ram_we),    32'd1);
    check("dl1_addr",  32'(ram_addr),  32'h0800000);
    check("dl1_wdata", 32'(ram_wdata), 32'h1234);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("dl1_stable_req",   32'(ram_req),   32'd1);
      check("dl1_stable_addr",  32'(ram_addr),  32'h0800000);
      check("dl1_stable_wdata", 32'(ram_wdata), 32'h1234);
    end
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    check("dl1_req_drop", 32'(ram_req), 32'd0);
    tick();
    check("dl1_no_repeat", 32'(ram_req), 32'd0);

    // Six back-to-back words with acks withheld: four fit, two dropped
    dl_downloading = 1'b0;
    tick();
    dl_downloading = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dl_wr = 1'b1; dl_addr = 25'h0100000 + 25'(i); dl_data = 16'hA000 + 16'(i);
      if (i < 4) exp_q.push_back({dl_addr, dl_data});
      tick();
    end
    dl_wr = 1'b0;
    check("ovf_set", 32'(dl_overflow), 32'd1);
    for (int i = 0; i < 4; i++) dl_service();
    tick();
    check("ovf_no_fifth", 32'(ram_req),     32'd0);
    check("ovf_sticky",   32'(dl_overflow), 32'd1);
    dl_downloading = 1'b0;

    // Download pending while CPU requests: download first, CPU after hold
    repeat (20) tick();
    check("hold_expired", 32'(cpu_reset), 32'd0);
    dl_wr = 1'b1; dl_addr = 25'h00ABCDE; dl_data = 16'h7777;
    exp_q.push_back({dl_addr, dl_data});
    tick();
    dl_wr = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h0000100; cpu_wdata = 16'h0;
    dl_service();
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("prio_cpu_blocked", 32'(ram_req),   32'd0);
      check("prio_cpu_reset",   32'(cpu_reset), 32'(k < 16));
    end
    tick();
    check("prio_cpu_grant", 32'(ram_req),  32'd1);
    check("prio_cpu_we",    32'(ram_we),   32'd0);
    check("prio_cpu_addr",  32'(ram_addr), 32'h0000100);
    ram_ack = 1'b1; ram_rdata = 16'hBEEF;
    tick();
    ram_ack = 1'b0; ram_rdata = 16'h0;
    check("prio_cpu_ack",   32'(cpu_ack),   32'd1);
    check("prio_cpu_rdata", 32'(cpu_rdata), 32'hBEEF);
    cpu_req = 1'b0;
    tick();

    // CPU write in flight when a download starts
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h000002A; cpu_wdata = 16'h5555;
    wait_req(30, ok);
    check("mid_we",   32'(ram_we),    32'd1);
    check("mid_addr", 32'(ram_addr),  32'h000002A);
    dl_downloading = 1'b1;
    dl_wr = 1'b1; dl_addr = 25'h1FFFFFF; dl_data = 16'hCAFE;
    exp_q.push_back({dl_addr, dl_data});
    tick();
    dl_wr = 1'b0;
    check("mid_ovf_clear", 32'(dl_overflow), 32'd0);
    check("mid_cpu_reset", 32'(cpu_reset),   32'd1);
    check("mid_req_held",  32'(ram_req),     32'd1);
    check("mid_wdata",     32'(ram_wdata),   32'h5555);
    ram_ack = 1'b1; ram_rdata = 16'h0F0F;
    tick();
    ram_ack = 1'b0; ram_rdata = 16'h0;
    check("mid_cpu_ack",   32'(cpu_ack),   32'd1);
    check("mid_cpu_rdata", 32'(cpu_rdata), 32'h0F0F);
    cpu_we = 1'b0; cpu_addr = 25'h0000033;
    dl_service();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_dl_block", 32'(ram_req), 32'd0);
    end
    dl_downloading = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("mid_hold_block", 32'(ram_req), 32'd0);
      check("mid_hold_ack",   32'(cpu_ack), 32'd0);
    end
    tick();
    check("mid_grant",      32'(ram_req),  32'd1);
    check("mid_grant_addr", 32'(ram_addr), 32'h0000033);
    ram_ack = 1'b1; ram_rdata = 16'h1357;
    tick();
    ram_ack = 1'b0;
    check("mid_rd_ack",   32'(cpu_ack),   32'd1);
    check("mid_rd_rdata", 32'(cpu_rdata), 32'h1357);
    cpu_req = 1'b0;
    tick();

    // Reset while a download write waits for its ack
    dl_downloading = 1'b1;
    dl_wr = 1'b1; dl_addr = 25'h00000F0; dl_data = 16'h4242;
    tick();
    dl_wr = 1'b0;
    wait_req(30, ok);
    reset = 1'b1; dl_downloading = 1'b0;
    tick();
    reset = 1'b0;
    check("abort_req",       32'(ram_req),   32'd0);
    check("abort_we",        32'(ram_we),    32'd0);
    check("abort_addr",      32'(ram_addr),  32'd0);
    check("abort_wdata",     32'(ram_wdata), 32'd0);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
    check("abort_rdata",     32'(cpu_rdata), 32'd0);
    ram_ack = 1'b1;
    tick();
    ram_ack = 1'b0;
    check("late_ack_req", 32'(ram_req), 32'd0);
    check("late_ack_cpu", 32'(cpu_ack), 32'd0);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("abort_no_req",   32'(ram_req),   32'd0);
      check("abort_hold",     32'(cpu_reset), 32'(k < 16));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
